ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares one single-port RAMHelper-style memory port (en, rIdx/rdata, wIdx/wdata/wmask/wen) between an instruction requester (read-only) and a data requester (read/write).
- Uses round-robin arbitration with valid/ready request and response handshakes.
- Holds one outstanding transaction at a time and registers the returned data.
- Sits between the core's fetch/LSU front-ends and the simulation RAM model.

Parameters:
- IDX_W, 64, width of the 64-bit word index.
- DATA_W, 64, data and mask width.
- CNT_W, 32, width of the per-requester grant counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_req_valid  in  1  instruction read request
- i_req_ready  out  1  instruction request accepted this cycle
- i_req_idx  in  IDX_W  instruction word index
- i_resp_valid  out  1  instruction response held
- i_resp_ready  in  1  instruction response consumed
- i_resp_rdata  out  DATA_W  instruction read data
- d_req_valid  in  1  data request
- d_req_ready  out  1  data request accepted this cycle
- d_req_idx  in  IDX_W  data word index
- d_req_wen  in  1  1 = write, 0 = read
- d_req_wdata  in  DATA_W  write data
- d_req_wmask  in  DATA_W  bit write mask
- d_resp_valid  out  1  data response held
- d_resp_ready  in  1  data response consumed
- d_resp_rdata  out  DATA_W  read data; for a write, the pre-write word
- ram_en  out  1  memory port enable
- ram_rIdx  out  IDX_W  read index
- ram_rdata  in  DATA_W  combinational read data from memory
- ram_wIdx  out  IDX_W  write index
- ram_wdata  out  DATA_W  write data
- ram_wmask  out  DATA_W  write mask
- ram_wen  out  1  write enable; the memory commits at posedge when ram_wen && ram_en
- i_grant_cnt  out  CNT_W  saturating count of accepted I requests
- d_grant_cnt  out  CNT_W  saturating count of accepted D requests

Behaviour:
- Reset values (rst_n low, asynchronous):
  - state = IDLE, last_grant = D.
  - All *_ready, *_resp_valid, ram_en and ram_wen are 0.
  - All ram_* index/data/mask outputs are 0.
  - resp_rdata registers and grant counters are 0.
- FSM states: IDLE, RESP_I, RESP_D.
- IDLE:
  - *_req_ready is high only for the granted requester and only in IDLE.
  - Grant rule:
    - Only one requester valid: that requester wins.
    - Both valid: the requester other than last_grant wins.
    - The first contended grant after reset therefore goes to I.
  - On grant, all of the following happen in the same cycle, combinationally from the granted request:
    - ram_en = 1.
    - ram_rIdx = granted idx.
    - For a D write: ram_wen = 1, ram_wIdx = d_req_idx, ram_wdata/ram_wmask = request values.
    - An I grant always drives ram_wen = 0.
  - At that posedge:
    - ram_rdata is captured into the granted resp_rdata register (a D write captures the pre-write value; the write commits at the same edge).
    - last_grant is updated.
    - The grant counter increments.
    - State moves to RESP_I or RESP_D.
  - No valid request: ram_en = 0 and all ram_* data/index outputs are 0.
- RESP_x:
  - x_resp_valid = 1 and resp_rdata is stable.
  - ram_en = 0 and both req_ready are 0.
  - On x_resp_valid && x_resp_ready, return to IDLE.
  - A new grant is possible at the earliest the next cycle, so one transaction takes at least 2 cycles.
- Requests may be held valid indefinitely; the arbiter never drops a valid request.
- Round-robin fairness: under continuous contention, grants strictly alternate I, D, I, D, ...
- Grant counters saturate at 2^CNT_W − 1 and do not wrap.
- Reset asserted mid-RESP:
  - The pending response is discarded and resp_valid drops immediately.
  - A write already committed at a prior edge is not undone.
  - Reset asserted in the same cycle as a grant: that write does not commit, because ram_en is forced low asynchronously.
- Response channels are independent in width but only one is ever valid at a time.

Decomposition:
- Shared package ram_arb_pkg:
  - State enum {IDLE, RESP_I, RESP_D}.
  - Requester id constants REQ_I = 0, REQ_D = 1.
  - Default width localparams.
- Natural sub-module: rr_arb2, a 2-input round-robin picker with a last_grant register, update enable and grant one-hot output.
- The top level holds the FSM, response registers, RAM port muxing and counters.

Test Plan:
- I-only read, idx = 0x10, memory word 0xDEADBEEF:
  - i_req_ready = 1 in the request cycle.
  - ram_en = 1 and ram_rIdx = 0x10 in that cycle.
  - Next cycle i_resp_valid = 1 and i_resp_rdata = 0xDEADBEEF.
  - i_grant_cnt = 1.
- D write idx = 0x20, wdata = 0x1122334455667788, wmask = 0x00000000FFFFFFFF, old word = 0xAAAAAAAABBBBBBBB:
  - d_resp_rdata = 0xAAAAAAAABBBBBBBB.
  - A following D read of 0x20 returns 0xAAAAAAAA55667788.
- Both valid continuously, responses consumed immediately:
  - Grant sequence after reset is I, D, I, D over 8 transactions.
  - Each grant is separated by 2 cycles.
  - Final counts are i_grant_cnt = 4 and d_grant_cnt = 4.
- Backpressure: hold i_resp_ready = 0 for 5 cycles after an I grant:
  - i_resp_valid and i_resp_rdata stay stable.
  - d_req_ready stays 0 despite d_req_valid = 1.
  - ram_en stays 0.
  - D is granted the cycle after i_resp_ready rises.
- Reset pulse (rst_n low for 1 cycle) while in RESP_D:
  - d_resp_valid falls immediately, with no clock needed.
  - State returns to IDLE and counters read 0.
  - The first subsequent contended grant goes to I.
- Counter saturation with CNT_W = 2:
  - After 5 I grants, i_grant_cnt holds at 3.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared definitions for the RAM port arbiter: state codes, requester ids,
// default widths.
package ram_arb_pkg;

    localparam int IDX_W_DEF  = 64;
    localparam int DATA_W_DEF = 64;
    localparam int CNT_W_DEF  = 32;

    // FSM state codes
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RESP_I = 2'd1;
    localparam logic [1:0] RESP_D = 2'd2;

    // Requester ids, used as bit positions in request/grant vectors
    localparam int REQ_I = 0;
    localparam int REQ_D = 1;

endpackage

// File: rtl/ram_port_arbiter_rr_arb2.sv
// Two-input round-robin picker. Under contention the requester that did not
// win last time is chosen; a lone requester always wins.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       upd,
    output logic [1:0] gnt
);

    // 1 = D was granted last; reset to D so the first contended grant goes to I
    logic last_d;

    // Pick a winner from the current requests and the last grant
    always_comb begin
        gnt = 2'b00;
        if (req[REQ_I] && (!req[REQ_D] || last_d))
            gnt[REQ_I] = 1'b1;
        else if (req[REQ_D])
            gnt[REQ_D] = 1'b1;
    end

    // Remember who won whenever a grant is actually taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_d <= 1'b1;
        else if (upd)
            last_d <= gnt[REQ_D];
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between an instruction reader and a data
// reader/writer. One transaction in flight; read data is registered and held
// until the owning requester consumes the response.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int IDX_W  = IDX_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req_valid,
    output logic              i_req_ready,
    input  logic [IDX_W-1:0]  i_req_idx,
    output logic              i_resp_valid,
    input  logic              i_resp_ready,
    output logic [DATA_W-1:0] i_resp_rdata,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic [IDX_W-1:0]  d_req_idx,
    input  logic              d_req_wen,
    input  logic [DATA_W-1:0] d_req_wdata,
    input  logic [DATA_W-1:0] d_req_wmask,
    output logic              d_resp_valid,
    input  logic              d_resp_ready,
    output logic [DATA_W-1:0] d_resp_rdata,
    output logic              ram_en,
    output logic [IDX_W-1:0]  ram_rIdx,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [IDX_W-1:0]  ram_wIdx,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [DATA_W-1:0] ram_wmask,
    output logic              ram_wen,
    output logic [CNT_W-1:0]  i_grant_cnt,
    output logic [CNT_W-1:0]  d_grant_cnt
);

    logic [1:0] state;
    logic [1:0] req;
    logic [1:0] gnt;
    logic       in_idle;
    logic       grant_i;
    logic       grant_d;

    // rst_n gates the grant path so a write in the reset cycle never commits
    assign in_idle    = (state == IDLE) && rst_n;
    assign req[REQ_I] = i_req_valid && in_idle;
    assign req[REQ_D] = d_req_valid && in_idle;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .upd   (|gnt),
        .gnt   (gnt)
    );

    assign grant_i      = gnt[REQ_I];
    assign grant_d      = gnt[REQ_D];
    assign i_req_ready  = grant_i;
    assign d_req_ready  = grant_d;
    assign i_resp_valid = (state == RESP_I);
    assign d_resp_valid = (state == RESP_D);

    // Drive the RAM port from the granted request; quiet bus otherwise
    always_comb begin
        ram_en    = 1'b0;
        ram_wen   = 1'b0;
        ram_rIdx  = '0;
        ram_wIdx  = '0;
        ram_wdata = '0;
        ram_wmask = '0;
        if (grant_i) begin
            ram_en   = 1'b1;
            ram_rIdx = i_req_idx;
        end else if (grant_d) begin
            ram_en   = 1'b1;
            ram_rIdx = d_req_idx;
            if (d_req_wen) begin
                ram_wen   = 1'b1;
                ram_wIdx  = d_req_idx;
                ram_wdata = d_req_wdata;
                ram_wmask = d_req_wmask;
            end
        end
    end

    // Transaction FSM: grant in IDLE, hold response until consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (grant_i) state <= RESP_I;
                         else if (grant_d) state <= RESP_D;
                RESP_I:  if (i_resp_ready) state <= IDLE;
                RESP_D:  if (d_resp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Capture read data on grant; for a D write this is the pre-write word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_resp_rdata <= '0;
            d_resp_rdata <= '0;
        end else begin
            if (grant_i) i_resp_rdata <= ram_rdata;
            if (grant_d) d_resp_rdata <= ram_rdata;
        end
    end

    // Saturating per-requester grant counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_grant_cnt <= '0;
            d_grant_cnt <= '0;
        end else begin
            if (grant_i && (i_grant_cnt != '1)) i_grant_cnt <= i_grant_cnt + 1'b1;
            if (grant_d && (d_grant_cnt != '1)) d_grant_cnt <= d_grant_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: a behavioural RAM, a reference copy of memory
// updated in grant order, and per-scenario tasks with inline checks.
module tb_ram_port_arbiter;

    localparam int IDX_W  = 64;
    localparam int DATA_W = 64;
    localparam int CNT_W  = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic              i_req_valid = 0, i_resp_ready = 0;
    logic [IDX_W-1:0]  i_req_idx = '0;
    logic              d_req_valid = 0, d_req_wen = 0, d_resp_ready = 0;
    logic [IDX_W-1:0]  d_req_idx = '0;
    logic [DATA_W-1:0] d_req_wdata = '0, d_req_wmask = '0;

    logic              i_req_ready, i_resp_valid, d_req_ready, d_resp_valid;
    logic [DATA_W-1:0] i_resp_rdata, d_resp_rdata;
    logic              ram_en, ram_wen;
    logic [IDX_W-1:0]  ram_rIdx, ram_wIdx;
    logic [DATA_W-1:0] ram_rdata, ram_wdata, ram_wmask;
    logic [CNT_W-1:0]  i_grant_cnt, d_grant_cnt;

    // second instance with narrow counters, driven by the same stimulus
    logic              s_i_req_ready, s_i_resp_valid, s_d_req_ready, s_d_resp_valid;
    logic [DATA_W-1:0] s_i_resp_rdata, s_d_resp_rdata;
    logic              s_ram_en, s_ram_wen;
    logic [IDX_W-1:0]  s_ram_rIdx, s_ram_wIdx;
    logic [DATA_W-1:0] s_ram_rdata, s_ram_wdata, s_ram_wmask;
    logic [1:0]        s_i_grant_cnt, s_d_grant_cnt;

    logic [DATA_W-1:0] mem     [0:255];
    logic [DATA_W-1:0] ref_mem [0:255];
    logic              fill = 1'b0;
    logic              pl_en = 1'b0;
    logic [7:0]        pl_idx = '0;
    logic [DATA_W-1:0] pl_data = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_i    = 0;
    int exp_d    = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(.IDX_W(IDX_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_idx(i_req_idx),
        .i_resp_valid(i_resp_valid), .i_resp_ready(i_resp_ready), .i_resp_rdata(i_resp_rdata),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_idx(d_req_idx),
        .d_req_wen(d_req_wen), .d_req_wdata(d_req_wdata), .d_req_wmask(d_req_wmask),
        .d_resp_valid(d_resp_valid), .d_resp_ready(d_resp_ready), .d_resp_rdata(d_resp_rdata),
        .ram_en(ram_en), .ram_rIdx(ram_rIdx), .ram_rdata(ram_rdata), .ram_wIdx(ram_wIdx),
        .ram_wdata(ram_wdata), .ram_wmask(ram_wmask), .ram_wen(ram_wen),
        .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt)
    );

    ram_port_arbiter #(.IDX_W(IDX_W), .DATA_W(DATA_W), .CNT_W(2)) sat_dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(i_req_valid), .i_req_ready(s_i_req_ready), .i_req_idx(i_req_idx),
        .i_resp_valid(s_i_resp_valid), .i_resp_ready(i_resp_ready), .i_resp_rdata(s_i_resp_rdata),
        .d_req_valid(d_req_valid), .d_req_ready(s_d_req_ready), .d_req_idx(d_req_idx),
        .d_req_wen(d_req_wen), .d_req_wdata(d_req_wdata), .d_req_wmask(d_req_wmask),
        .d_resp_valid(s_d_resp_valid), .d_resp_ready(d_resp_ready), .d_resp_rdata(s_d_resp_rdata),
        .ram_en(s_ram_en), .ram_rIdx(s_ram_rIdx), .ram_rdata(s_ram_rdata), .ram_wIdx(s_ram_wIdx),
        .ram_wdata(s_ram_wdata), .ram_wmask(s_ram_wmask), .ram_wen(s_ram_wen),
        .i_grant_cnt(s_i_grant_cnt), .d_grant_cnt(s_d_grant_cnt)
    );

    function automatic logic [DATA_W-1:0] init_word(input int i);
        return {32'(i) * 32'h01010101, ~32'(i)};
    endfunction

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                                input logic [DATA_W-1:0] new_w,
                                                input logic [DATA_W-1:0] mask);
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    // combinational-read RAM, committing at posedge on ram_en && ram_wen
    assign ram_rdata   = mem[ram_rIdx[7:0]];
    assign s_ram_rdata = mem[s_ram_rIdx[7:0]];

    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else if (pl_en) begin
            mem[pl_idx] <= pl_data;
        end else if (ram_en && ram_wen) begin
            mem[ram_wIdx[7:0]] <= merge(mem[ram_wIdx[7:0]], ram_wdata, ram_wmask);
        end
    end

    task automatic poke(input logic [7:0] idx, input logic [DATA_W-1:0] data);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = idx; pl_data = data;
        @(negedge clk);
        pl_en = 1'b0;
        ref_mem[idx] = data;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        i_req_valid = 0; d_req_valid = 0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_i = 0; exp_d = 0;
    endtask

    task automatic test_reset();
        // requests held valid during reset must not reach the RAM
        i_req_valid = 1; i_req_idx = 64'h7;
        d_req_valid = 1; d_req_wen = 1; d_req_idx = 64'h5;
        d_req_wdata = '1; d_req_wmask = '1;
        rst_n = 1'b0; fill = 1'b1;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        @(negedge clk); #1;
        n_checks++;
        if ({i_req_ready, d_req_ready, i_resp_valid, d_resp_valid, ram_en, ram_wen} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {i_req_ready, d_req_ready, i_resp_valid, d_resp_valid, ram_en, ram_wen});
        end
        n_checks++;
        if ({ram_rIdx, ram_wIdx, ram_wdata, ram_wmask} !== '0) begin
            n_fail++;
            $display("FAIL reset_ram_bus: rIdx %h wIdx %h wdata %h wmask %h expected all 0",
                     ram_rIdx, ram_wIdx, ram_wdata, ram_wmask);
        end
        n_checks++;
        if ({i_resp_rdata, d_resp_rdata, i_grant_cnt, d_grant_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: i_rdata %h d_rdata %h icnt %0d dcnt %0d expected 0",
                     i_resp_rdata, d_resp_rdata, i_grant_cnt, d_grant_cnt);
        end
        i_req_valid = 0; d_req_valid = 0; d_req_wen = 0;
        fill = 1'b0;
        rst_n = 1'b1;
        exp_i = 0; exp_d = 0;
    endtask

    task automatic test_i_read();
        poke(8'h10, 64'hDEADBEEF);
        @(negedge clk);
        i_req_valid = 1; i_req_idx = 64'h10; #1;
        n_checks++;
        if ({i_req_ready, d_req_ready, ram_en, ram_wen, ram_rIdx} !== {4'b1010, 64'h10}) begin
            n_fail++;
            $display("FAIL i_read_req: ready_i/ready_d/en/wen %b rIdx %h expected 1010 / 10",
                     {i_req_ready, d_req_ready, ram_en, ram_wen}, ram_rIdx);
        end
        exp_i++;
        @(negedge clk);
        i_req_valid = 0; #1;
        n_checks++;
        if (i_resp_valid !== 1'b1 || i_resp_rdata !== ref_mem[8'h10] || ram_en !== 1'b0) begin
            n_fail++;
            $display("FAIL i_read_resp: valid %b rdata %h en %b expected 1 %h 0",
                     i_resp_valid, i_resp_rdata, ram_en, ref_mem[8'h10]);
        end
        n_checks++;
        if (i_grant_cnt !== CNT_W'(exp_i)) begin
            n_fail++;
            $display("FAIL i_read_cnt: got %0d expected %0d", i_grant_cnt, exp_i);
        end
        i_resp_ready = 1;
        @(negedge clk); #1;
        n_checks++;
        if (i_resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL i_read_consume: i_resp_valid %b expected 0", i_resp_valid);
        end
        i_resp_ready = 0;
    endtask

    task automatic test_d_write();
        logic [DATA_W-1:0] old_w;
        poke(8'h20, 64'hAAAAAAAABBBBBBBB);
        old_w = ref_mem[8'h20];
        @(negedge clk);
        d_req_valid = 1; d_req_wen = 1; d_req_idx = 64'h20;
        d_req_wdata = 64'h1122334455667788; d_req_wmask = 64'h00000000FFFFFFFF; #1;
        n_checks++;
        if ({d_req_ready, ram_en, ram_wen, ram_wIdx, ram_wdata, ram_wmask} !==
            {3'b111, 64'h20, 64'h1122334455667788, 64'h00000000FFFFFFFF}) begin
            n_fail++;
            $display("FAIL d_write_req: ready/en/wen %b wIdx %h wdata %h wmask %h",
                     {d_req_ready, ram_en, ram_wen}, ram_wIdx, ram_wdata, ram_wmask);
        end
        ref_mem[8'h20] = merge(old_w, d_req_wdata, d_req_wmask);
        exp_d++;
        @(negedge clk);
        d_req_valid = 0; d_req_wen = 0; #1;
        n_checks++;
        if (d_resp_valid !== 1'b1 || d_resp_rdata !== 64'hAAAAAAAABBBBBBBB) begin
            n_fail++;
            $display("FAIL d_write_old: valid %b rdata %h expected 1 aaaaaaaabbbbbbbb",
                     d_resp_valid, d_resp_rdata);
        end
        d_resp_ready = 1;
        @(negedge clk);
        d_resp_ready = 0;
        d_req_valid = 1; d_req_idx = 64'h20; #1;
        exp_d++;
        @(negedge clk);
        d_req_valid = 0; #1;
        n_checks++;
        if (d_resp_rdata !== ref_mem[8'h20] || d_resp_rdata !== 64'hAAAAAAAA55667788) begin
            n_fail++;
            $display("FAIL d_readback: got %h expected %h", d_resp_rdata, ref_mem[8'h20]);
        end
        n_checks++;
        if (d_grant_cnt !== CNT_W'(exp_d)) begin
            n_fail++;
            $display("FAIL d_cnt: got %0d expected %0d", d_grant_cnt, exp_d);
        end
        d_resp_ready = 1;
        @(negedge clk);
        d_resp_ready = 0;
    endtask

    task automatic test_back_to_back();
        time last_t;
        int  who;
        logic [7:0] gidx;
        logic [DATA_W-1:0] exp_rd;
        apply_reset();
        i_resp_ready = 1; d_resp_ready = 1;
        i_req_idx = 64'($urandom_range(255));
        d_req_idx = 64'($urandom_range(255));
        d_req_wen = 1'($urandom_range(1));
        d_req_wdata = {$urandom, $urandom}; d_req_wmask = {$urandom, $urandom};
        last_t = 0;
        @(negedge clk);
        i_req_valid = 1; d_req_valid = 1; #1;
        for (int t = 0; t < 8; t++) begin
            for (int w = 0; w < 6 && !(i_req_ready || d_req_ready); w++) begin
                @(negedge clk); #1;
            end
            n_checks++;
            if (!(i_req_ready || d_req_ready)) begin
                n_fail++;
                $display("FAIL rr_timeout: no grant for transaction %0d", t);
                break;
            end
            who = d_req_ready ? 1 : 0;
            n_checks++;
            if (who != (t % 2)) begin
                n_fail++;
                $display("FAIL rr_order: txn %0d granted %s expected %s", t,
                         who ? "D" : "I", (t % 2) ? "D" : "I");
            end
            if (t > 0) begin
                n_checks++;
                if ($time - last_t != 20) begin
                    n_fail++;
                    $display("FAIL rr_spacing: txn %0d gap %0t expected 20", t, $time - last_t);
                end
            end
            last_t = $time;
            gidx = who ? d_req_idx[7:0] : i_req_idx[7:0];
            exp_rd = ref_mem[gidx];
            n_checks++;
            if (ram_rIdx !== 64'(gidx)) begin
                n_fail++;
                $display("FAIL rr_ridx: got %h expected %h", ram_rIdx, gidx);
            end
            if (who == 1) begin
                exp_d++;
                if (d_req_wen) ref_mem[gidx] = merge(ref_mem[gidx], d_req_wdata, d_req_wmask);
            end else begin
                exp_i++;
            end
            @(negedge clk); #1;
            n_checks++;
            if ((who ? d_resp_rdata : i_resp_rdata) !== exp_rd ||
                (who ? d_resp_valid : i_resp_valid) !== 1'b1) begin
                n_fail++;
                $display("FAIL rr_resp: txn %0d rdata %h expected %h", t,
                         who ? d_resp_rdata : i_resp_rdata, exp_rd);
            end
            if (who == 1) begin
                d_req_idx = 64'($urandom_range(255));
                d_req_wen = 1'($urandom_range(1));
                d_req_wdata = {$urandom, $urandom}; d_req_wmask = {$urandom, $urandom};
            end else begin
                i_req_idx = 64'($urandom_range(255));
            end
            @(negedge clk); #1;
        end
        i_req_valid = 0; d_req_valid = 0; d_req_wen = 0;
        n_checks++;
        if (i_grant_cnt !== CNT_W'(exp_i) || d_grant_cnt !== CNT_W'(exp_d) || exp_i != 4) begin
            n_fail++;
            $display("FAIL rr_counts: i %0d d %0d expected 4 4", i_grant_cnt, d_grant_cnt);
        end
        @(negedge clk);
        i_resp_ready = 0; d_resp_ready = 0;
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] exp_i_rd, exp_d_rd;
        i_resp_ready = 0; d_resp_ready = 0;
        i_req_idx = 64'($urandom_range(255));
        d_req_idx = 64'($urandom_range(255));
        d_req_wen = 0;
        @(negedge clk);
        i_req_valid = 1; d_req_valid = 1; #1;
        n_checks++;
        if ({i_req_ready, d_req_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL bp_grant_i: ready_i/ready_d %b expected 10", {i_req_ready, d_req_ready});
        end
        exp_i_rd = ref_mem[i_req_idx[7:0]];
        exp_d_rd = ref_mem[d_req_idx[7:0]];
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            i_req_valid = 0; #1;
            n_checks++;
            if ({i_resp_valid, d_req_ready, ram_en} !== 3'b100 || i_resp_rdata !== exp_i_rd) begin
                n_fail++;
                $display("FAIL bp_hold: cycle %0d valid/d_ready/en %b rdata %h expected 100 %h",
                         k, {i_resp_valid, d_req_ready, ram_en}, i_resp_rdata, exp_i_rd);
            end
        end
        i_resp_ready = 1;
        @(negedge clk); #1;
        n_checks++;
        if ({i_resp_valid, d_req_ready, ram_en} !== 3'b011) begin
            n_fail++;
            $display("FAIL bp_d_after: valid_i/d_ready/en %b expected 011",
                     {i_resp_valid, d_req_ready, ram_en});
        end
        i_resp_ready = 0;
        @(negedge clk);
        d_req_valid = 0; #1;
        n_checks++;
        if (d_resp_valid !== 1'b1 || d_resp_rdata !== exp_d_rd) begin
            n_fail++;
            $display("FAIL bp_d_resp: valid %b rdata %h expected 1 %h", d_resp_valid, d_resp_rdata, exp_d_rd);
        end
        d_resp_ready = 1;
        @(negedge clk);
        d_resp_ready = 0;
    endtask

    task automatic test_reset_mid_resp();
        logic [DATA_W-1:0] wd, wm;
        wd = {$urandom, $urandom}; wm = {$urandom, $urandom};
        d_resp_ready = 0;
        @(negedge clk);
        d_req_valid = 1; d_req_wen = 1; d_req_idx = 64'h30; d_req_wdata = wd; d_req_wmask = wm; #1;
        ref_mem[8'h30] = merge(ref_mem[8'h30], wd, wm);
        @(negedge clk);
        d_req_valid = 0; d_req_wen = 0; #1;
        n_checks++;
        if (d_resp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre_valid: d_resp_valid %b expected 1", d_resp_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (d_resp_valid !== 1'b0 || d_grant_cnt !== '0 || i_grant_cnt !== '0) begin
            n_fail++;
            $display("FAIL rst_async_drop: valid %b icnt %0d dcnt %0d expected 0 0 0",
                     d_resp_valid, i_grant_cnt, d_grant_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_i = 0; exp_d = 0;
        i_resp_ready = 1; d_resp_ready = 1;
        i_req_idx = 64'($urandom_range(255));
        d_req_idx = 64'h30;
        @(negedge clk);
        i_req_valid = 1; d_req_valid = 1; #1;
        n_checks++;
        if ({i_req_ready, d_req_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL rst_first_contended: ready_i/ready_d %b expected 10", {i_req_ready, d_req_ready});
        end
        @(negedge clk);
        i_req_valid = 0;
        @(negedge clk); #1;
        n_checks++;
        if (d_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_d_next: d_req_ready %b expected 1", d_req_ready);
        end
        @(negedge clk);
        d_req_valid = 0; #1;
        n_checks++;
        if (d_resp_rdata !== ref_mem[8'h30]) begin
            n_fail++;
            $display("FAIL rst_write_kept: got %h expected %h", d_resp_rdata, ref_mem[8'h30]);
        end
        @(negedge clk);
        i_resp_ready = 0; d_resp_ready = 0;
    endtask

    task automatic test_saturation();
        int exp_s;
        apply_reset();
        i_resp_ready = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            i_req_valid = 1; i_req_idx = 64'($urandom_range(255));
            @(negedge clk);
            i_req_valid = 0; #1;
            exp_i++;
            exp_s = (exp_i > 3) ? 3 : exp_i;
            n_checks++;
            if (s_i_grant_cnt !== 2'(exp_s) || i_grant_cnt !== CNT_W'(exp_i)) begin
                n_fail++;
                $display("FAIL sat_cnt: grant %0d narrow %0d wide %0d expected %0d %0d",
                         k + 1, s_i_grant_cnt, i_grant_cnt, exp_s, exp_i);
            end
        end
        @(negedge clk);
        i_resp_ready = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_i_read();
        test_d_write();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_resp();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
